restador_pipe: RTL and testbench

RESTADOR_PIPE -- requirements
Module: restador_pipe

---
 rtl/restador_pipe_pkg.sv | 16 +
 rtl/restador_pipe_if.sv | 27 ++
 rtl/restador_pipe_core.sv | 13 +
 rtl/restador_pipe.sv | 90 +++++++++
 tb/tb_restador_pipe.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/restador_pipe_pkg.sv
// Shared constants and types for the restador_pipe subtractor.
// Defining RESTADOR_SAT_EN clamps the result to zero on an unsigned borrow.
package restador_pipe_pkg;

  localparam int ANCHO = 5;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [ANCHO-1:0] resultado;
    logic             borrow;
    logic             zero;
    logic             negativo;
    logic             overflow;
  } resultado_t;

endpackage

// File: rtl/restador_pipe_if.sv
// Operand/result handshake bundle for restador_pipe; slave is the pipe side.
interface restador_pipe_if;
  import restador_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ANCHO-1:0] minuendo;
  logic [ANCHO-1:0] sustraendo;
  logic             out_valid;
  logic             out_ready;
  logic [ANCHO-1:0] resultado;
  logic             borrow;
  logic             zero;
  logic             negativo;
  logic             overflow;
  logic [CNT_W-1:0] num_ops;

  modport slave (
    input  in_valid, minuendo, sustraendo, out_ready,
    output in_ready, out_valid, resultado, borrow, zero, negativo, overflow, num_ops
  );

  modport master (
    output in_valid, minuendo, sustraendo, out_ready,
    input  in_ready, out_valid, resultado, borrow, zero, negativo, overflow, num_ops
  );
endinterface

// File: rtl/restador_pipe_core.sv
// Raw modular difference a - b via two's-complement addition; no flags here.
module restador_core
  import restador_pipe_pkg::*;
(
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    output logic [ANCHO-1:0] diff
);

    // Carry out of the top bit is dropped by the 5-bit result width.
    assign diff = a + (~b + ANCHO'(1));

endmodule

// File: rtl/restador_pipe.sv
// Two-stage valid/ready subtractor: S1 holds operands, S2 holds result and flags.
// Optional RESTADOR_SAT_EN: result forced to zero whenever borrow is set.
module restador_pipe
  import restador_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    restador_pipe_if.slave  bus
);

    logic             v1;
    logic             v2;
    logic [ANCHO-1:0] m1;
    logic [ANCHO-1:0] s1;
    logic [ANCHO-1:0] raw;
    logic             s1_load;
    logic             s2_load;
    logic             take;
    resultado_t       s2_d;
    resultado_t       s2_q;

    assign s2_load      = v1 && (!v2 || bus.out_ready);
    assign bus.in_ready = !v1 || !v2 || bus.out_ready;
    assign s1_load      = bus.in_valid && bus.in_ready;
    assign take         = v2 && bus.out_ready;

    restador_core u_core (
        .a    (m1),
        .b    (s1),
        .diff (raw)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        s2_d          = '0;
        s2_d.borrow   = (m1 < s1);
        s2_d.overflow = (m1[ANCHO-1] != s1[ANCHO-1]) && (raw[ANCHO-1] != m1[ANCHO-1]);
`ifdef RESTADOR_SAT_EN
        s2_d.resultado = s2_d.borrow ? '0 : raw;
`else
        s2_d.resultado = raw;
`endif
        s2_d.zero     = (s2_d.resultado == '0);
        s2_d.negativo = s2_d.resultado[ANCHO-1];
    end

    // NOTE: state registers use non-blocking assignments so all stages update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            m1 <= '0;
            s1 <= '0;
        end else if (s1_load) begin
            v1 <= 1'b1;
            m1 <= bus.minuendo;
            s1 <= bus.sustraendo;
        end else if (s2_load) begin
            v1 <= 1'b0;
        end
    end

    // S2 only loads when drained or being drained, so a stalled result never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            s2_q <= '0;
        end else if (s2_load) begin
            v2   <= 1'b1;
            s2_q <= s2_d;
        end else if (take) begin
            v2 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.num_ops <= '0;
        end else if (take) begin
            bus.num_ops <= bus.num_ops + CNT_W'(1);
        end
    end

    assign bus.out_valid = v2;
    assign bus.resultado = s2_q.resultado;
    assign bus.borrow    = s2_q.borrow;
    assign bus.zero      = s2_q.zero;
    assign bus.negativo  = s2_q.negativo;
    assign bus.overflow  = s2_q.overflow;

endmodule

// File: tb/tb_restador_pipe.sv
// Scoreboard bench for restador_pipe: directed vectors, back-pressure, reset, streaming.
module tb_restador_pipe;
    import restador_pipe_pkg::*;

    logic clk;
    logic rst_n;
    restador_pipe_if bus ();

    restador_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_taken  = 0;
    resultado_t sb[$];

    typedef struct {
        int m, s, res, b, z, n, o;
    } vec_t;

    function automatic resultado_t model(input int m, input int s);
        resultado_t r;
        int sm, ss, d;
        r.borrow = (m < s);
        sm = (m >= 16) ? m - 32 : m;
        ss = (s >= 16) ? s - 32 : s;
        d  = sm - ss;
        r.overflow  = (d > 15) || (d < -16);
        r.resultado = 5'((m - s + 32) % 32);
`ifdef RESTADOR_SAT_EN
        if (r.borrow) r.resultado = '0;
`endif
        r.zero     = (r.resultado == 5'd0);
        r.negativo = r.resultado[4];
        return r;
    endfunction

    function automatic resultado_t observed();
        resultado_t r;
        r.resultado = bus.resultado;
        r.borrow    = bus.borrow;
        r.zero      = bus.zero;
        r.negativo  = bus.negativo;
        r.overflow  = bus.overflow;
        return r;
    endfunction

    // Called at a falling edge: samples handshakes, scores output, then advances one cycle.
    task automatic tick();
        logic acc, take;
        resultado_t exp_r, got;
        #1;
        acc  = bus.in_valid && bus.in_ready;
        take = bus.out_valid && bus.out_ready;
        if (take) begin
            checks++;
            got = observed();
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow: got result %h with no expected entry", got);
            end else begin
                exp_r = sb.pop_front();
                if (got !== exp_r) begin
                    failures++;
                    $display("FAIL sb_result: got res=%0d b=%b z=%b n=%b o=%b expected res=%0d b=%b z=%b n=%b o=%b",
                             got.resultado, got.borrow, got.zero, got.negativo, got.overflow,
                             exp_r.resultado, exp_r.borrow, exp_r.zero, exp_r.negativo, exp_r.overflow);
                end
            end
            n_taken++;
        end
        if (acc) begin
            sb.push_back(model(int'(bus.minuendo), int'(bus.sustraendo)));
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_num_ops(input string name);
        checks++;
        if (bus.num_ops !== 8'(n_taken)) begin
            failures++;
            $display("FAIL %s: num_ops=%0d expected %0d", name, bus.num_ops, 8'(n_taken));
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain_timeout: %0d results still pending, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.minuendo   = '0;
        bus.sustraendo = '0;
        bus.out_ready  = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.num_ops !== 8'd0 || observed() !== resultado_t'(0)) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b num_ops=%0d outs=%h expected 0 0 0",
                     bus.out_valid, bus.num_ops, observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: in_ready=%b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t dir[5];
        resultado_t got, want;
`ifdef RESTADOR_SAT_EN
        dir[0] = '{9, 4, 5, 0, 0, 0, 0};
        dir[1] = '{3, 7, 0, 1, 1, 0, 0};
        dir[2] = '{12, 0, 12, 0, 0, 0, 0};
        dir[3] = '{15, 16, 0, 1, 1, 0, 1};
        dir[4] = '{0, 0, 0, 0, 1, 0, 0};
`else
        dir[0] = '{9, 4, 5, 0, 0, 0, 0};
        dir[1] = '{3, 7, 28, 1, 0, 1, 0};
        dir[2] = '{12, 0, 12, 0, 0, 0, 0};
        dir[3] = '{15, 16, 31, 1, 0, 1, 1};
        dir[4] = '{0, 0, 0, 0, 1, 0, 0};
`endif
        bus.out_ready = 1'b1;
        foreach (dir[i]) begin
            bus.in_valid   = 1'b1;
            bus.minuendo   = 5'(dir[i].m);
            bus.sustraendo = 5'(dir[i].s);
            tick();
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL latency_early[%0d]: out_valid=%b expected 0", i, bus.out_valid);
            end
            tick();
            got  = observed();
            want = '{5'(dir[i].res), 1'(dir[i].b), 1'(dir[i].z), 1'(dir[i].n), 1'(dir[i].o)};
            checks++;
            if (bus.out_valid !== 1'b1 || got !== want) begin
                failures++;
                $display("FAIL directed[%0d] %0d-%0d: out_valid=%b res=%0d b=%b z=%b n=%b o=%b expected 1 res=%0d b=%b z=%b n=%b o=%b",
                         i, dir[i].m, dir[i].s, bus.out_valid, got.resultado, got.borrow, got.zero,
                         got.negativo, got.overflow, want.resultado, want.borrow, want.zero,
                         want.negativo, want.overflow);
            end
            tick();
        end
        check_num_ops("directed_num_ops");
    endtask

    task automatic test_back_pressure();
        int base, idx;
        int mv[4] = '{20, 1, 7, 8};
        int sv[4] = '{5, 30, 7, 2};
        logic have;
        resultado_t held;
        base = n_acc;
        have = 1'b0;
        held = '0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idx            = (n_acc - base) % 4;
            bus.minuendo   = 5'(mv[idx]);
            bus.sustraendo = 5'(sv[idx]);
            tick();
            if (bus.out_valid) begin
                if (!have) begin
                    held = observed();
                    have = 1'b1;
                end else begin
                    checks++;
                    if (observed() !== held) begin
                        failures++;
                        $display("FAIL bp_hold_stable: outs=%h expected %h", observed(), held);
                    end
                end
            end
        end
        checks++;
        if (n_acc - base != 2) begin
            failures++;
            $display("FAIL bp_accept_count: accepted=%0d expected 2", n_acc - base);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b expected 0 1", bus.in_ready, bus.out_valid);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("bp");
        check_num_ops("bp_num_ops");
    endtask

    task automatic test_reset_midstream();
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.minuendo   = 5'd17;
        bus.sustraendo = 5'd3;
        for (int i = 0; i < 4 && bus.in_ready; i++) tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_fill: in_ready=%b out_valid=%b expected 0 1", bus.in_ready, bus.out_valid);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.num_ops !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_clear: out_valid=%b num_ops=%0d expected 0 0", bus.out_valid, bus.num_ops);
        end
        sb.delete();
        n_taken      = 0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_release: in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int base_acc;
        base_acc      = n_acc;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.minuendo   = 5'($urandom_range(0, 31));
            bus.sustraendo = 5'($urandom_range(0, 31));
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (n_acc - base_acc != 256 || n_taken != 254) begin
            failures++;
            $display("FAIL stream_rate: accepted=%0d taken=%0d expected 256 254", n_acc - base_acc, n_taken);
        end
        tick();
        checks++;
        if (bus.num_ops !== 8'd255) begin
            failures++;
            $display("FAIL stream_num_ops_255: num_ops=%0d expected 255", bus.num_ops);
        end
        tick();
        checks++;
        if (sb.size() != 0 || bus.num_ops !== 8'd0) begin
            failures++;
            $display("FAIL stream_wrap: pending=%0d num_ops=%0d expected 0 0", sb.size(), bus.num_ops);
        end
        drain("stream");
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_directed();
        test_back_pressure();
        test_reset_midstream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
